// File: rtl/phy_link_sync_ctrl.sv
// phy_link_sync_ctrl: COM-based lane sync, data forwarding and stall-driven loss of sync
module phy_link_sync_ctrl #(
  parameter logic [7:0] COMMA      = 8'hBC,
  parameter int         SYNC_COUNT = 4,
  parameter int         LOSS_COUNT = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       active,
  output logic       unstrip_reset,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic [1:0] state_dbg,
  output logic [7:0] loss_cnt
);
  typedef enum logic [1:0] {SEARCH = 2'd0, COUNT = 2'd1, SYNCED = 2'd2, DATA = 2'd3} state_t;
  state_t     state_q, state_d;
  logic       active_q, active_d, unstrip_reset_q, unstrip_reset_d, data_valid_q, data_valid_d;
  logic [7:0] data_out_q, data_out_d, loss_cnt_q, loss_cnt_d;
  logic [3:0] com_cnt_q, com_cnt_d, stall_cnt_q, stall_cnt_d;
  logic       is_com, is_dat;
  assign is_com = rx_valid && rx_data == COMMA;
  assign is_dat = rx_valid && rx_data != COMMA;
  always_comb begin
    state_d      = state_q;
    com_cnt_d    = com_cnt_q;
    stall_cnt_d  = 4'd0;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    loss_cnt_d   = loss_cnt_q;
    case (state_q)
      SEARCH: if (is_com) begin
        state_d   = COUNT;
        com_cnt_d = 4'd1;
      end
      COUNT: if (is_com) begin
        com_cnt_d = com_cnt_q + 4'd1;
        state_d   = com_cnt_q == 4'(SYNC_COUNT - 1) ? SYNCED : COUNT;
      end else if (is_dat) begin
        state_d   = SEARCH;
        com_cnt_d = 4'd0;
      end
      default: begin
        stall_cnt_d = rx_valid ? 4'd0 : stall_cnt_q + 4'd1;
        if (is_dat) begin
          state_d      = DATA;
          data_out_d   = rx_data;
          data_valid_d = 1'b1;
        end
        if (!rx_valid && stall_cnt_q == 4'(LOSS_COUNT - 1)) begin
          state_d     = SEARCH;
          com_cnt_d   = 4'd0;
          stall_cnt_d = 4'd0;
          loss_cnt_d  = loss_cnt_q == 8'hFF ? loss_cnt_q : loss_cnt_q + 8'd1;
        end
      end
    endcase
    active_d        = state_d == SYNCED || state_d == DATA;
    unstrip_reset_d = state_d != DATA;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= SEARCH;
      active_q        <= 1'b0;
      unstrip_reset_q <= 1'b1;
      data_out_q      <= 8'h00;
      data_valid_q    <= 1'b0;
      loss_cnt_q      <= 8'h00;
      com_cnt_q       <= 4'd0;
      stall_cnt_q     <= 4'd0;
    end else begin
      state_q         <= state_d;
      active_q        <= active_d;
      unstrip_reset_q <= unstrip_reset_d;
      data_out_q      <= data_out_d;
      data_valid_q    <= data_valid_d;
      loss_cnt_q      <= loss_cnt_d;
      com_cnt_q       <= com_cnt_d;
      stall_cnt_q     <= stall_cnt_d;
    end
  end
  assign active        = active_q;
  assign unstrip_reset = unstrip_reset_q;
  assign data_out      = data_out_q;
  assign data_valid    = data_valid_q;
  assign state_dbg     = state_q;
  assign loss_cnt      = loss_cnt_q;
endmodule

// File: tb/tb_phy_link_sync_ctrl.sv
// tb_phy_link_sync_ctrl: scoreboard bench for the lane sync controller
module tb_phy_link_sync_ctrl;
  typedef struct packed {
    logic       act;
    logic       ur;
    logic       dv;
    logic [7:0] dout;
    logic [1:0] st;
    logic [7:0] loss;
  } exp_t;
  typedef struct packed {
    logic       r;
    logic       v;
    logic [7:0] d;
  } stim_t;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] rx_data = 8'hBC;
  logic       rx_valid = 1'b1;
  logic       active, unstrip_reset, data_valid;
  logic [7:0] data_out, loss_cnt;
  logic [1:0] state_dbg;
  int         checks = 0;
  int         passes = 0;
  stim_t      stim_q[$];
  exp_t       sb[$];
  phy_link_sync_ctrl dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .active(active), .unstrip_reset(unstrip_reset), .data_out(data_out),
    .data_valid(data_valid), .state_dbg(state_dbg), .loss_cnt(loss_cnt)
  );
  always #5 clk = ~clk;
  function automatic exp_t e(logic act, logic ur, logic dv, logic [7:0] dout, logic [1:0] st, logic [7:0] loss);
    return '{act, ur, dv, dout, st, loss};
  endfunction
  function automatic exp_t snap();
    return '{active, unstrip_reset, data_valid, data_out, state_dbg, loss_cnt};
  endfunction
  task automatic push(logic r, logic v, logic [7:0] d, exp_t x);
    stim_q.push_back('{r, v, d});
    sb.push_back(x);
  endtask
  task automatic step(stim_t s);
    reset    = s.r;
    rx_valid = s.v;
    rx_data  = s.d;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    exp_t got, x;
    push(1, 1, 8'hBC, e(0, 1, 0, 8'h00, 0, 0));
    push(1, 1, 8'hBC, e(0, 1, 0, 8'h00, 0, 0));
    for (int i = 0; stim_q.size() > 0; i++) begin
      step(stim_q.pop_front());
      got = snap();
      x = sb.pop_front();
      checks++;
      if (got !== x) $display("FAIL reset[%0d] got %h want %h", i, got, x);
      else passes++;
    end
  endtask
  task automatic test_sync();
    exp_t got, x;
    push(0, 1, 8'hBC, e(0, 1, 0, 8'h00, 1, 0));
    push(0, 1, 8'hBC, e(0, 1, 0, 8'h00, 1, 0));
    push(0, 1, 8'hBC, e(0, 1, 0, 8'h00, 1, 0));
    push(0, 1, 8'hBC, e(1, 1, 0, 8'h00, 2, 0));
    push(0, 1, 8'hBC, e(1, 1, 0, 8'h00, 2, 0));
    for (int i = 0; stim_q.size() > 0; i++) begin
      step(stim_q.pop_front());
      got = snap();
      x = sb.pop_front();
      checks++;
      if (got !== x) $display("FAIL sync[%0d] got %h want %h", i, got, x);
      else passes++;
    end
  endtask
  task automatic test_data();
    exp_t got, x;
    push(0, 1, 8'hFF, e(1, 0, 1, 8'hFF, 3, 0));
    push(0, 1, 8'hFF, e(1, 0, 1, 8'hFF, 3, 0));
    push(0, 1, 8'hF4, e(1, 0, 1, 8'hF4, 3, 0));
    push(0, 1, 8'hBC, e(1, 0, 0, 8'hF4, 3, 0));
    push(0, 1, 8'hE8, e(1, 0, 1, 8'hE8, 3, 0));
    for (int i = 0; stim_q.size() > 0; i++) begin
      step(stim_q.pop_front());
      got = snap();
      x = sb.pop_front();
      checks++;
      if (got !== x) $display("FAIL data[%0d] got %h want %h", i, got, x);
      else passes++;
    end
  endtask
  task automatic test_abort();
    exp_t got, x;
    push(1, 1, 8'hBC, e(0, 1, 0, 8'h00, 0, 0));
    for (int k = 0; k < 3; k++) push(0, 1, 8'hBC, e(0, 1, 0, 8'h00, 1, 0));
    push(0, 1, 8'h7F, e(0, 1, 0, 8'h00, 0, 0));
    for (int k = 0; k < 3; k++) push(0, 1, 8'hBC, e(0, 1, 0, 8'h00, 1, 0));
    push(0, 1, 8'hBC, e(1, 1, 0, 8'h00, 2, 0));
    push(0, 1, 8'h11, e(1, 0, 1, 8'h11, 3, 0));
    for (int i = 0; stim_q.size() > 0; i++) begin
      step(stim_q.pop_front());
      got = snap();
      x = sb.pop_front();
      checks++;
      if (got !== x) $display("FAIL abort[%0d] got %h want %h", i, got, x);
      else passes++;
    end
  endtask
  task automatic test_stall();
    exp_t got, x;
    push(0, 0, 8'h99, e(1, 0, 0, 8'h11, 3, 0));
    push(0, 0, 8'h99, e(1, 0, 0, 8'h11, 3, 0));
    push(0, 1, 8'h22, e(1, 0, 1, 8'h22, 3, 0));
    push(0, 0, 8'h99, e(1, 0, 0, 8'h22, 3, 0));
    push(0, 0, 8'h99, e(1, 0, 0, 8'h22, 3, 0));
    push(0, 0, 8'h99, e(0, 1, 0, 8'h22, 0, 1));
    push(0, 0, 8'h99, e(0, 1, 0, 8'h22, 0, 1));
    push(0, 1, 8'h33, e(0, 1, 0, 8'h22, 0, 1));
    push(0, 1, 8'hBC, e(0, 1, 0, 8'h22, 1, 1));
    push(0, 1, 8'hBC, e(0, 1, 0, 8'h22, 1, 1));
    push(0, 0, 8'hBC, e(0, 1, 0, 8'h22, 1, 1));
    push(0, 1, 8'hBC, e(0, 1, 0, 8'h22, 1, 1));
    push(0, 1, 8'hBC, e(1, 1, 0, 8'h22, 2, 1));
    push(0, 1, 8'h33, e(1, 0, 1, 8'h33, 3, 1));
    push(0, 0, 8'h99, e(1, 0, 0, 8'h33, 3, 1));
    push(0, 0, 8'h99, e(1, 0, 0, 8'h33, 3, 1));
    push(0, 1, 8'hBC, e(1, 0, 0, 8'h33, 3, 1));
    push(0, 0, 8'h99, e(1, 0, 0, 8'h33, 3, 1));
    push(0, 0, 8'h99, e(1, 0, 0, 8'h33, 3, 1));
    push(0, 0, 8'h99, e(0, 1, 0, 8'h33, 0, 2));
    for (int i = 0; stim_q.size() > 0; i++) begin
      step(stim_q.pop_front());
      got = snap();
      x = sb.pop_front();
      checks++;
      if (got !== x) $display("FAIL stall[%0d] got %h want %h", i, got, x);
      else passes++;
    end
  endtask
  task automatic test_reset_mid();
    exp_t got, x;
    for (int k = 0; k < 3; k++) push(0, 1, 8'hBC, e(0, 1, 0, 8'h33, 1, 2));
    push(0, 1, 8'hBC, e(1, 1, 0, 8'h33, 2, 2));
    push(0, 1, 8'h44, e(1, 0, 1, 8'h44, 3, 2));
    push(1, 1, 8'h55, e(0, 1, 0, 8'h00, 0, 0));
    push(0, 1, 8'h66, e(0, 1, 0, 8'h00, 0, 0));
    for (int i = 0; stim_q.size() > 0; i++) begin
      step(stim_q.pop_front());
      got = snap();
      x = sb.pop_front();
      checks++;
      if (got !== x) $display("FAIL reset_mid[%0d] got %h want %h", i, got, x);
      else passes++;
    end
  endtask
  initial begin
    test_reset();
    test_sync();
    test_data();
    test_abort();
    test_stall();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
